// File: rtl/vslc_scan_scheduler.sv
// rtl/vslc_scan_scheduler.sv - VSLC program header parser, scan scheduler and reader watchdog
// Optional build macro SCAN_COUNT_EN adds the scan_count output and scan_count_clr input.
module vslc_scan_scheduler #(
    parameter int ADDR_W    = 10,
    parameter int PERIOD_W  = 16,
    parameter int WDT_LIMIT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic                trig_in,
    input  logic                read_ready,
    input  logic [ADDR_W-1:0]   addr_read,
    input  logic [7:0]          read_data,
    output logic                restart_read,
    output logic [ADDR_W-1:0]   start_addr,
    output logic [ADDR_W-1:0]   end_addr,
    output logic                instr_ready,
    output logic                scan_strobe,
    output logic                scan_done,
    output logic                overrun,
    output logic                fault,
`ifdef SCAN_COUNT_EN
    input  logic                scan_count_clr,
    output logic [15:0]         scan_count,
`endif
    output logic [2:0]          state_o
);

    localparam int WDT_W = $clog2(WDT_LIMIT + 1);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_RUN   = 3'd1,
        S_WAIT  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          start_q, start_d;
    logic [9:0]          end_q, end_d;
    logic [WDT_W-1:0]    wdt_q, wdt_d;
    logic [PERIOD_W-1:0] timer_q;
    logic                pending_q;
    logic                overrun_q;
    logic [2:0]          trig_q;
    logic [1:0]          mode_q;
    logic                trig_edge;
    logic                period_hit;
    logic                go;

    // trig_q[1:0] is the synchronizer; trig_q[2] holds the previous synchronized value
    assign trig_edge  = trig_q[1] & ~trig_q[2];
    assign period_hit = (period == '0) || (timer_q >= period - PERIOD_W'(1));

    assign start_addr = ADDR_W'(start_q);
    assign end_addr   = ADDR_W'(end_q);
    assign overrun    = overrun_q;
    assign fault      = (state_q == S_FAULT);
    assign state_o    = state_q;

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        end_d        = end_q;
        wdt_d        = wdt_q;
        restart_read = 1'b0;
        scan_strobe  = 1'b0;
        scan_done    = 1'b0;
        instr_ready  = 1'b0;
        go           = 1'b0;
        case (state_q)
            S_HDR: begin
                if (read_ready) begin
                    if (addr_read == ADDR_W'(0)) start_d[9:8] = read_data[1:0];
                    if (addr_read == ADDR_W'(1)) start_d[7:0] = read_data;
                    if (addr_read == ADDR_W'(2)) end_d[9:8]   = read_data[1:0];
                    if (addr_read == ADDR_W'(3)) begin
                        end_d[7:0] = read_data;
                        if ({end_q[9:8], read_data} < 10'd4) begin
                            state_d = S_HALT;
                        end else begin
                            state_d     = S_RUN;
                            scan_strobe = 1'b1;
                        end
                    end
                end
            end
            S_RUN: begin
                instr_ready = read_ready && (addr_read > ADDR_W'(3));
                if (read_ready && (addr_read >= end_addr)) begin
                    scan_done = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                case (mode)
                    2'd0:    go = 1'b1;
                    2'd1:    go = trig_edge || pending_q;
                    2'd2:    go = period_hit;
                    default: go = 1'b0;
                endcase
                if (go) begin
                    restart_read = 1'b1;
                    scan_strobe  = 1'b1;
                    state_d      = S_RUN;
                end
            end
            S_HALT, S_FAULT: ;
            default: state_d = S_HDR;
        endcase

        // A byte arriving on the expiry cycle keeps the reader alive
        if (state_q == S_HDR || state_q == S_RUN) begin
            if (read_ready) begin
                wdt_d = '0;
            end else if (wdt_q == WDT_W'(WDT_LIMIT - 1)) begin
                wdt_d   = '0;
                state_d = S_FAULT;
            end else begin
                wdt_d = wdt_q + WDT_W'(1);
            end
        end
        if (state_d == S_RUN && state_q != S_RUN) wdt_d = '0;

        if (rst) begin
            restart_read = 1'b0;
            scan_strobe  = 1'b0;
            scan_done    = 1'b0;
            instr_ready  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HDR;
            start_q <= '0;
            end_q   <= '0;
            wdt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            wdt_q   <= wdt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            trig_q    <= '0;
            mode_q    <= '0;
        end else begin
            trig_q <= {trig_q[1:0], trig_in};
            mode_q <= mode;
            if (scan_strobe)          timer_q <= '0;
            else if (timer_q != '1)   timer_q <= timer_q + PERIOD_W'(1);
            if (scan_strobe || (mode != mode_q))      pending_q <= 1'b0;
            else if (trig_edge && state_q != S_WAIT)  pending_q <= 1'b1;
            if (state_q == S_RUN && mode == 2'd2 && period != '0 && period_hit)
                overrun_q <= 1'b1;
        end
    end

`ifdef SCAN_COUNT_EN
    logic [15:0] scan_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 scan_count_q <= '0;
        else if (scan_count_clr) scan_count_q <= '0;
        else if (scan_strobe)    scan_count_q <= scan_count_q + 16'd1;
    end

    assign scan_count = scan_count_q;
`endif

endmodule

// File: doc/vslc_scan_scheduler.md
Name: vslc_scan_scheduler

Overview:
Sequences the EEPROM program reader for the VSLC core. Parses the 4-byte program header once after reset and gates instruction delivery to the executor. Decides when each new scan cycle starts: free-running, external trigger or fixed period. Supervises the reader with a watchdog and emits the scan strobe used to latch the input image.

Parameters:
ADDR_W, 10, EEPROM address width
PERIOD_W, 16, width of period timer and period input
WDT_LIMIT, 1024, clk cycles without read_ready before FAULT

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
mode  in  2  0 free-run, 1 external trigger, 2 periodic, 3 stop-after-scan
period  in  PERIOD_W  periodic mode scan interval in clk cycles
trig_in  in  1  asynchronous external scan trigger
read_ready  in  1  reader byte-valid strobe, one cycle
addr_read  in  ADDR_W  address of byte on read_data
read_data  in  8  byte from reader
restart_read  out  1  one-cycle pulse: reader restarts at start_addr
start_addr  out  ADDR_W  parsed program start
end_addr  out  ADDR_W  parsed program end
instr_ready  out  1  read_ready qualified for executor
scan_strobe  out  1  one-cycle pulse at every scan start; latches inputs
scan_done  out  1  one-cycle pulse when end_addr byte consumed
overrun  out  1  sticky: periodic scan exceeded period
fault  out  1  watchdog fault, sticky until rst
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (async, rst=1): state=HDR, all outputs 0, addresses 0, timers 0, pending 0. Single clock domain; trig_in passes a 2-flop synchronizer, and a rising edge on the synchronized signal is an event.
- States: HDR=0, RUN=1, WAIT=2, HALT=3, FAULT=4.
- HDR: on read_ready, capture by addr_read. 0 gives start[9:8]=data[1:0]; 1 gives start[7:0]; 2 gives end[9:8]=data[1:0]; 3 gives end[7:0]. instr_ready=0. After addr 3: if end_addr<4 (empty program) -> HALT, else -> RUN, pulsing scan_strobe in the same cycle as the transition.
- RUN: instr_ready = read_ready && addr_read>3, combinational. On read_ready && addr_read>=end_addr: scan_done pulse, -> WAIT. An addr_read past end_addr (reader overshoot) is treated the same.
- WAIT, by mode sampled each cycle:
  - 0: start immediately.
  - 1: start on trigger edge, or at once if pending=1.
  - 2: start when period timer >= period.
  - 3: stay in WAIT.
  - Start = restart_read and scan_strobe pulsed together for one cycle, pending cleared, -> RUN.
- pending: a trigger edge seen in any state other than WAIT sets pending (depth 1; further edges are lost). Cleared at scan start and at mode change.
- Period timer: cleared at each scan start, then increments and saturates at all-ones. period=0 behaves as free-run. If the timer reaches period while in RUN, overrun is set (sticky until rst) and the next scan starts on the first WAIT cycle.
- Watchdog: counter cleared on every read_ready and on entry to HDR/RUN. Counts only in HDR and RUN. At WDT_LIMIT -> FAULT. FAULT: fault=1, no restart, instr_ready=0. Exit from FAULT only via rst.
- HALT: terminal until rst. Outputs idle, instr_ready=0.
- read_ready simultaneous with a watchdog expiry: read_ready wins and the counter clears.
- Reset mid-scan drops to HDR immediately; the header is re-parsed from the reader's next bytes.

Optional Feature:
SCAN_COUNT_EN: when defined, adds output scan_count (16 bits), incremented at every scan_strobe, wrapping 0xFFFF->0, reset to 0. It also adds input scan_count_clr (1 bit), a synchronous clear; if the clear coincides with a strobe, the result is 0. When undefined, neither port exists and there is no counter logic.

Test Plan:
- Header bytes 00,04,00,08 then bytes at addr 4..8, mode=0 -> start=4, end=8; instr_ready high for 5 bytes; scan_done at addr 8; restart_read+scan_strobe in the next cycle.
- Header with end bytes 00,02 -> HALT (state_o=3); instr_ready stays 0 on later read_ready; no restart ever.
- mode=1, trigger edge during RUN -> pending; on entry to WAIT, restart within 1 cycle. Second trigger edge during the same RUN -> only one extra scan.
- mode=2, period=50, scan taking 30 cycles -> strobes 50 cycles apart, overrun=0. Stretch a scan to 60 cycles -> overrun=1, immediate restart.
- No read_ready for WDT_LIMIT cycles in RUN -> fault=1, state_o=4. Stays faulted until rst pulse; rst then returns all outputs to 0 and state to HDR.
- With SCAN_COUNT_EN defined: 3 scans -> scan_count=3. scan_count_clr asserted together with a strobe -> 0.
